// File: rtl/candidate_pkg.sv
// Shared constants, FSM encoding and helpers for the candidate bank scanner.
package candidate_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 5;
    localparam int MAX_ENTRIES = 16;
    localparam int IDX_WIDTH   = 4;
    // One extra bit so a full 16-entry count is representable.
    localparam int CNT_WIDTH   = IDX_WIDTH + 1;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    function automatic logic [CNT_WIDTH-1:0] clamp_entries(input logic [CNT_WIDTH-1:0] n);
        return (n > CNT_WIDTH'(MAX_ENTRIES)) ? CNT_WIDTH'(MAX_ENTRIES) : n;
    endfunction

endpackage

// File: rtl/candidate_scanner_if.sv
// Request/result and bank read-port bundle between the scanner and its user.
interface candidate_scanner_if;
    import candidate_pkg::*;

    // start is a request taken only while the scanner is idle (busy=0); it is
    // never queued. done pulses once per accepted start, results valid with it.
    logic                  start;
    logic                  mode;
    logic [CNT_WIDTH-1:0]  num_entries;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic                  rd_en;
    logic [WORD_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [IDX_WIDTH-1:0]  best_idx;
    logic [WORD_WIDTH-1:0] best_val;

    modport master (
        output start, mode, num_entries, rd_data,
        input  rd_index, rd_en, busy, done, found, best_idx, best_val
    );

    modport slave (
        input  start, mode, num_entries, rd_data,
        output rd_index, rd_en, busy, done, found, best_idx, best_val
    );

endinterface

// File: rtl/candidate_compare.sv
// Registered select stage: keeps the running best entry of a scan.
module candidate_compare
    import candidate_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  valid,
    input  logic                  first,
    input  logic                  mode,
    input  logic [WORD_WIDTH-1:0] value,
    input  logic [IDX_WIDTH-1:0]  idx,
    output logic [WORD_WIDTH-1:0] best_val,
    output logic [IDX_WIDTH-1:0]  best_idx,
    output logic                  found
);

    logic better;

    // Strict comparison: on a tie the earlier (lower) index stays the winner.
    always_comb begin
        better = 1'b0;
        if (mode == MODE_MAX) better = (value > best_val);
        else                  better = (value < best_val);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_val <= '0;
            best_idx <= '0;
            found    <= 1'b0;
        end else if (valid && (first || better)) begin
            best_val <= value;
            best_idx <= idx;
            found    <= 1'b1;
        end
    end

endmodule

// File: rtl/candidate_scanner.sv
// Walks the first N bank entries one per cycle and reports the max/min entry.
module candidate_scanner
    import candidate_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    candidate_scanner_if.slave  bus,
    output scan_state_t         dbg_state
);

    scan_state_t          state, state_nxt;
    logic [CNT_WIDTH-1:0] k, k_nxt;
    logic [CNT_WIDTH-1:0] n_q;
    logic                 mode_q;
    logic                 accept;

    logic                  p_valid;
    logic                  p_first;
    logic [WORD_WIDTH-1:0] p_val;
    logic [IDX_WIDTH-1:0]  p_idx;

    assign accept    = (state == ST_IDLE) && bus.start;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            k      <= '0;
            n_q    <= '0;
            mode_q <= MODE_MAX;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            if (accept) begin
                n_q    <= clamp_entries(bus.num_entries);
                mode_q <= bus.mode;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    k_nxt     = '0;
                    state_nxt = (bus.num_entries == '0) ? ST_DONE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                k_nxt = k + CNT_WIDTH'(1);
                // n_q is at least 1 here, so the last index never wraps.
                if (k == n_q - CNT_WIDTH'(1)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign bus.rd_en    = (state == ST_SCAN);
    assign bus.rd_index = (state == ST_SCAN) ? {k[IDX_WIDTH-1:0], 1'b0} : '0;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);

    // Read data is combinational from the bank; capture it with its index so
    // the compare runs one cycle behind the address walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_val   <= '0;
            p_idx   <= '0;
        end else begin
            p_valid <= (state == ST_SCAN);
            p_first <= (k == '0);
            p_val   <= bus.rd_data;
            p_idx   <= k[IDX_WIDTH-1:0];
        end
    end

    candidate_compare u_compare (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .valid    (p_valid),
        .first    (p_first),
        .mode     (mode_q),
        .value    (p_val),
        .idx      (p_idx),
        .best_val (bus.best_val),
        .best_idx (bus.best_idx),
        .found    (bus.found)
    );

endmodule

// File: tb/tb_candidate_scanner.sv
// Directed and randomized scans of candidate_scanner against a simple bank model.
module tb_candidate_scanner;
    import candidate_pkg::*;

    logic        clk;
    logic        rst;
    scan_state_t dbg_state;
    logic [15:0] bank [16];

    int vectors;
    int miscompares;

    candidate_scanner_if sif ();

    candidate_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (sif.slave),
        .dbg_state (dbg_state)
    );

    assign sif.rd_data = bank[sif.rd_index[4:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: best of the first n words, first occurrence wins ties.
    task automatic model(input logic m, input int n, output logic f, output int bi,
                         output logic [15:0] bv);
        f = 1'b0; bi = 0; bv = 16'h0;
        for (int i = 0; i < n; i++) begin
            if (!f || (m == 1'b0 && bank[i] > bv) || (m == 1'b1 && bank[i] < bv)) begin
                bv = bank[i];
                bi = i;
                f  = 1'b1;
            end
        end
    endtask

    task automatic run_scan(input logic m, input logic [4:0] n, input string tag);
        int nc, reads, lat;
        logic f_e;
        int bi_e;
        logic [15:0] bv_e;
        bit seen;
        nc = (n > 5'd16) ? 16 : int'(n);
        model(m, nc, f_e, bi_e, bv_e);
        @(posedge clk); #1;
        sif.start = 1'b1; sif.mode = m; sif.num_entries = n;
        @(posedge clk); #1;
        // Scramble the request inputs to prove they were latched at start.
        sif.start = 1'b0; sif.mode = ~m; sif.num_entries = 5'($urandom_range(0, 31));
        reads = 0; lat = 0; seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            chk({tag, " busy"}, sif.busy, 1);
            chk({tag, " rd_en"}, sif.rd_en, (c <= nc) ? 1 : 0);
            if (sif.rd_en) begin
                chk({tag, " rd_index"}, sif.rd_index, 32'(2 * reads));
                reads++;
            end
            if (sif.done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk({tag, " done_seen"}, seen, 1);
        chk({tag, " latency"}, lat, (nc == 0) ? 1 : nc + 2);
        chk({tag, " reads"}, reads, nc);
        chk({tag, " found"}, sif.found, f_e);
        chk({tag, " best_idx"}, sif.best_idx, bi_e);
        chk({tag, " best_val"}, sif.best_val, bv_e);
        @(negedge clk);
        chk({tag, " busy_after"}, sif.busy, 0);
        chk({tag, " done_after"}, sif.done, 0);
        chk({tag, " found_hold"}, sif.found, f_e);
        chk({tag, " best_idx_hold"}, sif.best_idx, bi_e);
        chk({tag, " best_val_hold"}, sif.best_val, bv_e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rd_en"}, sif.rd_en, 0);
        chk({tag, " rd_index"}, sif.rd_index, 0);
        chk({tag, " busy"}, sif.busy, 0);
        chk({tag, " done"}, sif.done, 0);
        chk({tag, " found"}, sif.found, 0);
        chk({tag, " best_idx"}, sif.best_idx, 0);
        chk({tag, " best_val"}, sif.best_val, 0);
    endtask

    initial begin
        int dones;
        logic f_e;
        int bi_e;
        logic [15:0] bv_e;
        vectors = 0;
        miscompares = 0;
        sif.start = 1'b0;
        sif.mode = 1'b0;
        sif.num_entries = '0;
        for (int i = 0; i < 16; i++) bank[i] = 16'($urandom);

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        // Small bank with a tie at the maximum
        bank[0] = 16'h0010; bank[1] = 16'h0300; bank[2] = 16'h0200; bank[3] = 16'h0300;
        run_scan(1'b0, 5'd4, "n4_max");
        run_scan(1'b1, 5'd4, "n4_min");
        run_scan(1'b0, 5'd0, "n0");

        // Full bank, largest at the last entry
        for (int i = 0; i < 16; i++) bank[i] = 16'(i * 16'h0101);
        bank[15] = 16'hFFFF;
        run_scan(1'b0, 5'd16, "n16_max");
        run_scan(1'b1, 5'd16, "n16_min");
        run_scan(1'b0, 5'd20, "n20_clamp");

        // Reset in the middle of an 8-entry scan
        @(posedge clk); #1;
        sif.start = 1'b1; sif.mode = 1'b0; sif.num_entries = 5'd8;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sif.done) dones++;
        end
        chk("mid_reset no_done", dones, 0);
        run_scan(1'($urandom), 5'd2, "restart_n2");

        // Starts while busy and in the done cycle are ignored
        for (int i = 0; i < 16; i++) bank[i] = 16'($urandom);
        model(1'b0, 5, f_e, bi_e, bv_e);
        @(posedge clk); #1;
        sif.start = 1'b1; sif.mode = 1'b0; sif.num_entries = 5'd5;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(posedge clk); #1;
        sif.start = 1'b1; sif.mode = 1'b1; sif.num_entries = 5'd3;
        @(posedge clk); #1;
        sif.start = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sif.done) begin
                dones++;
                sif.start = 1'b1;
                @(posedge clk); #1;
                sif.start = 1'b0;
            end
        end
        chk("busy_start dones", dones, 1);
        chk("busy_start busy", sif.busy, 0);
        chk("busy_start best_idx", sif.best_idx, bi_e);
        chk("busy_start best_val", sif.best_val, bv_e);

        // Randomized scans
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 16; i++)
                bank[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            run_scan(1'($urandom), 5'($urandom_range(0, 20)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
